uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Consumes the UART DMA receive frame stream: 0x55, CMD, LEN, then LEN payload bytes.
- Decodes register write and register read commands and drives a simple 32-bit register bus.
- Builds a response frame and pushes it into the UART DMA send stream (tdata/tlast/tvalid/tready).
- Sits between the UART DMA block's receive output and its send input, closing the host command loop.

Parameters:
- CMD_WR, 8'h01, opcode for register write.
- CMD_RD, 8'h02, opcode for register read.
- RD_TIMEOUT, 255, cycles to wait for i_reg_rd_valid before reporting a timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_uart_DMA_rdata  in  8  received frame byte.
- i_uart_DMA_rvalid  in  1  byte valid; no backpressure is possible.
- i_uart_DMA_rlast  in  1  final byte of frame; coincides with the last rvalid.
- i_uart_DMA_rlen  in  8  total frame length; informational, not used for checking.
- o_uart_DMA_tdata  out  8  response byte.
- o_uart_DMA_tlast  out  1  last response byte.
- o_uart_DMA_tvalid  out  1  response byte valid.
- i_uart_DMA_tready  in  1  send side ready.
- o_reg_wr_en  out  1  write strobe.
- o_reg_rd_en  out  1  read strobe.
- o_reg_addr  out  8  register address.
- o_reg_wdata  out  32  write data.
- i_reg_rdata  in  32  read data.
- i_reg_rd_valid  in  1  read data valid.
- o_drop_cnt  out  16  frames dropped while busy; saturating.

Behaviour:
- Reset: every output is 0. State is IDLE; counters and buffers are cleared. Reset mid-frame or mid-response aborts it immediately; tvalid drops in the next cycle.
- States: IDLE, RX, EXEC, WAIT_RD, RESP, DRAIN.
- IDLE to RX on rvalid. The byte counter counts every rvalid byte; bytes are captured by index. Byte 0 = header, byte 1 = CMD, byte 2 = LEN. Bytes 3..7 are kept; later bytes are discarded.
- Byte 0 != 0x55: go to DRAIN. Ignore bytes until rlast, send no response, return to IDLE.
- At rlast go to EXEC, which checks the frame in this priority order:
  - count != 3+LEN gives status 0x04 (length mismatch);
  - CMD not CMD_WR or CMD_RD gives 0x02;
  - CMD_WR with LEN != 5, or CMD_RD with LEN != 1, gives 0x01;
  - otherwise status 0x00.
- Write: addr = byte 3, wdata = bytes 4..7 big-endian. o_reg_wr_en pulses one cycle in EXEC, with addr and wdata stable from that cycle until the next command.
- Read: o_reg_rd_en pulses one cycle in EXEC, then WAIT_RD. Capture i_reg_rdata when i_reg_rd_valid is seen. If no valid arrives by the RD_TIMEOUT cycle after the strobe, status = 0x03 and data = 0. An i_reg_rd_valid that coincides with the timeout cycle wins.
- No strobe is issued on any error status.
- Response frame: 0x55, CMD|0x80, RLEN, STATUS, then 4 read-data bytes MSB first only for a successful read.
  - RLEN = 5 for a successful read, otherwise 1.
  - Total length is 4 or 8 bytes.
- RESP: tvalid is held with tdata stable until tready. A byte advances only on tvalid&tready. tlast is asserted with the final byte. Back to IDLE after the last handshake.
- First response byte appears no later than 2 cycles after EXEC, or after the WAIT_RD exit.
- Frames arriving in EXEC, WAIT_RD or RESP are ignored. o_drop_cnt increments once per such frame at its rlast and saturates at 0xFFFF.
- A frame that starts in the same cycle RESP completes is accepted.
- Single-byte frame (rvalid with rlast together) with header 0x55: status 0x04, CMD echoed as 0x80.

Optional Feature:
- Macro UART_CMD_CHECKSUM_EN.
- Defined:
  - LEN includes one trailing byte equal to the XOR of CMD, LEN and all preceding payload bytes.
  - CMD_WR expects LEN = 6; CMD_RD expects LEN = 2.
  - A checksum mismatch gives status 0x05. It is checked after the length and opcode checks and before the expected-LEN check.
  - Responses also carry a trailing XOR byte, so RLEN is incremented by 1.
- Undefined: no checksum byte in either direction; logic is absent.

Test Plan:
- Write: feed 55 01 05 10 DE AD BE EF (rlast on EF), tready=1 -> one o_reg_wr_en pulse with addr=0x10, wdata=0xDEADBEEF; response 55 81 01 00, tlast on 00.
- Read: feed 55 02 01 20; i_reg_rd_valid 3 cycles after the strobe with rdata 0x12345678 -> response 55 82 05 00 12 34 56 78.
- Read timeout: same frame with valid never asserted -> response 55 82 01 03 after 255 cycles.
- Errors:
  - 55 07 00 -> 55 87 01 02;
  - 55 01 05 10 AA (early rlast) -> status 04, no strobe;
  - AA 01 00 -> no response.
- Backpressure and drop:
  - toggle tready 1/0 every cycle during a read response -> bytes unchanged and in order;
  - inject a frame during RESP -> o_drop_cnt = 1, no second response.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Bundles the UART DMA receive/send streams, the 32-bit register bus and the drop counter.
// The parser uses the slave modport; the host side (DMA block, register file) uses master.
interface uart_cmd_parser_if;
  logic [7:0]  i_uart_DMA_rdata;
  logic        i_uart_DMA_rvalid;
  logic        i_uart_DMA_rlast;
  logic [7:0]  i_uart_DMA_rlen;
  logic [7:0]  o_uart_DMA_tdata;
  logic        o_uart_DMA_tlast;
  logic        o_uart_DMA_tvalid;
  logic        i_uart_DMA_tready;
  logic        o_reg_wr_en;
  logic        o_reg_rd_en;
  logic [7:0]  o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic [31:0] i_reg_rdata;
  logic        i_reg_rd_valid;
  logic [15:0] o_drop_cnt;

  modport slave (
    input  i_uart_DMA_rdata, i_uart_DMA_rvalid, i_uart_DMA_rlast, i_uart_DMA_rlen,
    input  i_uart_DMA_tready, i_reg_rdata, i_reg_rd_valid,
    output o_uart_DMA_tdata, o_uart_DMA_tlast, o_uart_DMA_tvalid,
    output o_reg_wr_en, o_reg_rd_en, o_reg_addr, o_reg_wdata, o_drop_cnt
  );

  modport master (
    output i_uart_DMA_rdata, i_uart_DMA_rvalid, i_uart_DMA_rlast, i_uart_DMA_rlen,
    output i_uart_DMA_tready, i_reg_rdata, i_reg_rd_valid,
    input  o_uart_DMA_tdata, o_uart_DMA_tlast, o_uart_DMA_tvalid,
    input  o_reg_wr_en, o_reg_rd_en, o_reg_addr, o_reg_wdata, o_drop_cnt
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses 0x55/CMD/LEN/payload frames into register bus accesses and streams back a response.
// Define UART_CMD_CHECKSUM_EN to add a trailing XOR byte to both request and response frames.
module uart_cmd_parser #(
  parameter logic [7:0] CMD_WR     = 8'h01,
  parameter logic [7:0] CMD_RD     = 8'h02,
  parameter int         RD_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  uart_cmd_parser_if.slave bus
);

  localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [7:0] WR_LEN = 8'd6;
  localparam logic [7:0] RD_LEN = 8'd2;
  localparam logic [7:0] EXTRA  = 8'd1;
`else
  localparam logic [7:0] WR_LEN = 8'd5;
  localparam logic [7:0] RD_LEN = 8'd1;
  localparam logic [7:0] EXTRA  = 8'd0;
`endif

  typedef enum logic [2:0] {IDLE, RX, EXEC, WAIT_RD, RESP, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [7:0]      cmd_q, cmd_d, len_q, len_d, xor_q, xor_d;
  logic [4:0][7:0] pay_q, pay_d;
  logic            dropping_q, dropping_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [7:0]      status_q, status_d, rlen_q, rlen_d;
  logic [31:0]     rdata_q, rdata_d, wdata_q, wdata_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      tdata_q, tdata_d, addr_q, addr_d;
  logic            tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic            wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [7:0]       exec_status, resp_xor;
  logic [3:0]       resp_last;
  logic [15:0][7:0] resp_vec;
  logic             start_frame, busy, absorb, unused_rlen;

  assign unused_rlen = ^bus.i_uart_DMA_rlen;

  // Frame validity in priority order: byte count, opcode, checksum, expected LEN.
  always_comb begin
    exec_status = 8'h00;
    if ({1'b0, len_q} + 9'd3 != cnt_q)
      exec_status = 8'h04;
    else if (cmd_q != CMD_WR && cmd_q != CMD_RD)
      exec_status = 8'h02;
`ifdef UART_CMD_CHECKSUM_EN
    else if (xor_q != 8'h00)
      exec_status = 8'h05;
`endif
    else if ((cmd_q == CMD_WR && len_q != WR_LEN) || (cmd_q == CMD_RD && len_q != RD_LEN))
      exec_status = 8'h01;
  end

  always_comb begin
    resp_last = 4'(rlen_q + 8'd2);
    resp_xor  = (cmd_q | 8'h80) ^ rlen_q ^ status_q ^
                rdata_q[31:24] ^ rdata_q[23:16] ^ rdata_q[15:8] ^ rdata_q[7:0];
    resp_vec    = '0;
    resp_vec[0] = 8'h55;
    resp_vec[1] = cmd_q | 8'h80;
    resp_vec[2] = rlen_q;
    resp_vec[3] = status_q;
    resp_vec[4] = rdata_q[31:24];
    resp_vec[5] = rdata_q[23:16];
    resp_vec[6] = rdata_q[15:8];
    resp_vec[7] = rdata_q[7:0];
`ifdef UART_CMD_CHECKSUM_EN
    resp_vec[resp_last] = resp_xor;
`endif
  end

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  cmd_d = cmd_q;  len_d = len_q;  xor_d = xor_q;
    pay_d = pay_q;  dropping_d = dropping_q;  drop_cnt_d = drop_cnt_q;
    status_d = status_q;  rlen_d = rlen_q;  rdata_d = rdata_q;  wdata_d = wdata_q;
    idx_d = idx_q;  tdata_d = tdata_q;  addr_d = addr_q;  tlast_d = tlast_q;
    tvalid_d = tvalid_q;  timer_d = timer_q;
    wr_en_d = 1'b0;  rd_en_d = 1'b0;
    start_frame = 1'b0;
    busy   = (state_q == EXEC) || (state_q == WAIT_RD) || (state_q == RESP);
    absorb = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_uart_DMA_rvalid) begin
          if (dropping_q) absorb = 1'b1;
          else            start_frame = 1'b1;
        end
      end
      RX: begin
        if (bus.i_uart_DMA_rvalid) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 9'd1;
          xor_d = xor_q ^ bus.i_uart_DMA_rdata;
          if (cnt_q == 9'd1) cmd_d = bus.i_uart_DMA_rdata;
          if (cnt_q == 9'd2) len_d = bus.i_uart_DMA_rdata;
          if (cnt_q >= 9'd3 && cnt_q <= 9'd7) pay_d[3'(cnt_q - 9'd3)] = bus.i_uart_DMA_rdata;
          if (bus.i_uart_DMA_rlast) state_d = EXEC;
        end
      end
      DRAIN: begin
        if (bus.i_uart_DMA_rvalid && bus.i_uart_DMA_rlast) state_d = IDLE;
      end
      EXEC: begin
        status_d = exec_status;
        rlen_d   = 8'd1 + EXTRA;
        rdata_d  = '0;
        if (exec_status == 8'h00 && cmd_q == CMD_RD) begin
          rd_en_d = 1'b1;
          addr_d  = pay_q[0];
          timer_d = '0;
          state_d = WAIT_RD;
        end else begin
          if (exec_status == 8'h00) begin
            wr_en_d = 1'b1;
            addr_d  = pay_q[0];
            wdata_d = {pay_q[1], pay_q[2], pay_q[3], pay_q[4]};
          end
          state_d = RESP;  idx_d = '0;  tdata_d = 8'h55;  tvalid_d = 1'b1;  tlast_d = 1'b0;
        end
      end
      WAIT_RD: begin
        // A valid arriving on the timeout cycle itself still counts as a successful read.
        if (bus.i_reg_rd_valid || timer_q == TW'(RD_TIMEOUT)) begin
          status_d = bus.i_reg_rd_valid ? 8'h00 : 8'h03;
          rlen_d   = bus.i_reg_rd_valid ? 8'd5 + EXTRA : 8'd1 + EXTRA;
          rdata_d  = bus.i_reg_rd_valid ? bus.i_reg_rdata : 32'h0;
          state_d = RESP;  idx_d = '0;  tdata_d = 8'h55;  tvalid_d = 1'b1;  tlast_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.i_uart_DMA_tready) begin
          if (tlast_q) begin
            state_d = IDLE;  tvalid_d = 1'b0;  tlast_d = 1'b0;  tdata_d = 8'h00;
            if (bus.i_uart_DMA_rvalid && !dropping_q) start_frame = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            tdata_d = resp_vec[idx_q + 4'd1];
            tlast_d = (idx_q + 4'd1 == resp_last);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frames overlapping a busy command are swallowed whole, even if their tail lands in IDLE.
    if (bus.i_uart_DMA_rvalid && ((busy && !start_frame) || absorb)) begin
      dropping_d = !bus.i_uart_DMA_rlast;
      if (bus.i_uart_DMA_rlast && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (start_frame) begin
      cnt_d = 9'd1;  cmd_d = '0;  len_d = '0;  pay_d = '0;  xor_d = '0;
      if (bus.i_uart_DMA_rdata == 8'h55)
        state_d = bus.i_uart_DMA_rlast ? EXEC : RX;
      else
        state_d = bus.i_uart_DMA_rlast ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;  cnt_q <= '0;  cmd_q <= '0;  len_q <= '0;  xor_q <= '0;
      pay_q <= '0;  dropping_q <= 1'b0;  drop_cnt_q <= '0;
      status_q <= '0;  rlen_q <= '0;  rdata_q <= '0;  wdata_q <= '0;
      idx_q <= '0;  tdata_q <= '0;  addr_q <= '0;  tlast_q <= 1'b0;
      tvalid_q <= 1'b0;  timer_q <= '0;  wr_en_q <= 1'b0;  rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  cmd_q <= cmd_d;  len_q <= len_d;  xor_q <= xor_d;
      pay_q <= pay_d;  dropping_q <= dropping_d;  drop_cnt_q <= drop_cnt_d;
      status_q <= status_d;  rlen_q <= rlen_d;  rdata_q <= rdata_d;  wdata_q <= wdata_d;
      idx_q <= idx_d;  tdata_q <= tdata_d;  addr_q <= addr_d;  tlast_q <= tlast_d;
      tvalid_q <= tvalid_d;  timer_q <= timer_d;  wr_en_q <= wr_en_d;  rd_en_q <= rd_en_d;
    end
  end

  assign bus.o_uart_DMA_tdata  = tdata_q;
  assign bus.o_uart_DMA_tlast  = tlast_q;
  assign bus.o_uart_DMA_tvalid = tvalid_q;
  assign bus.o_reg_wr_en       = wr_en_q;
  assign bus.o_reg_rd_en       = rd_en_q;
  assign bus.o_reg_addr        = addr_q;
  assign bus.o_reg_wdata       = wdata_q;
  assign bus.o_drop_cnt        = drop_cnt_q;

endmodule
